// File: rtl/mem_access_ctrl.sv
// Memory-stage controller sitting behind the EX/MEM pipeline register.
// Issues read/write strobes to a multi-cycle data memory and holds them
// until MemDone. It stalls the upstream pipeline while an access is
// outstanding, and it never reissues a finished access while EX/MEM is
// frozen. It also sequences halt and latches fatal access errors.
// Strobes, Stall and the ReadData bypass are combinational, so a memory
// that answers in the same cycle completes with no stall.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Address,
    input  logic [15:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemToReg,
    input  logic        Halt,
    input  logic        StallIn,
    input  logic        MemDone,
    input  logic [15:0] MemDataOut,
    output logic        MemRdEn,
    output logic        MemWrEn,
    output logic [15:0] MemAddr,
    output logic [15:0] MemDataIn,
    output logic [15:0] ReadData,
    output logic        MemToReg_Out,
    output logic        Stall,
    output logic        Halt_Out,
    output logic        Err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY   = 3'd1,
        HOLD   = 3'd2,
        HALTED = 3'd3,
        ERROR  = 3'd4
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [15:0] rd_q_r;
    logic        halt_r;
    logic        err_r;

    logic        req_s;
    logic        bad_s;
    logic        rd_en_s;
    logic        wr_en_s;
    logic        stall_s;
    logic [7:0]  cnt_inc_s;
    logic        cnt_hit_s;
    logic [15:0] read_data_s;

    // Request qualification, error screening, strobes, stall and read bypass.
    always_comb begin
        req_s       = 1'b0;
        bad_s       = 1'b0;
        rd_en_s     = 1'b0;
        wr_en_s     = 1'b0;
        stall_s     = 1'b0;
        cnt_inc_s   = cnt_r;
        cnt_hit_s   = 1'b0;
        read_data_s = rd_q_r;

        if ((state_r == IDLE) || (state_r == BUSY)) begin
            req_s = MemRead | MemWrite;
        end else begin
            req_s = 1'b0;
        end

        // Screening happens only at issue. A BUSY access was already screened.
        if (req_s && (state_r == IDLE)) begin
            bad_s = (MemRead & MemWrite) | Address[0];
        end else begin
            bad_s = 1'b0;
        end

        rd_en_s = MemRead  & req_s & ~bad_s;
        wr_en_s = MemWrite & req_s & ~bad_s;
        stall_s = (req_s & ~bad_s & ~MemDone) | ((state_r == HOLD) & StallIn);

        // The counter saturates so that a long wait never wraps past TIMEOUT.
        if (cnt_r == 8'hFF) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + 8'd1;
        end
        cnt_hit_s = (cnt_inc_s >= TIMEOUT_C);

        if (rd_en_s && MemDone) begin
            read_data_s = MemDataOut;
        end else begin
            read_data_s = rd_q_r;
        end
    end

    assign MemRdEn      = rd_en_s;
    assign MemWrEn      = wr_en_s;
    assign MemAddr      = Address;
    assign MemDataIn    = WriteData;
    assign ReadData     = read_data_s;
    assign MemToReg_Out = MemToReg;
    assign Stall        = stall_s;
    assign Halt_Out     = halt_r;
    assign Err          = err_r;

    // Access FSM with wait counter, sticky halt/error flags and load-data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            rd_q_r  <= 16'd0;
            halt_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            if (rd_en_s && MemDone) begin
                rd_q_r <= MemDataOut;
            end

            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        if (bad_s) begin
                            state_r <= ERROR;
                            err_r   <= 1'b1;
                            halt_r  <= 1'b1;
                        end else if (MemDone) begin
                            state_r <= StallIn ? HOLD : IDLE;
                        end else if (TIMEOUT_C <= 8'd1) begin
                            state_r <= ERROR;
                            err_r   <= 1'b1;
                            halt_r  <= 1'b1;
                        end else begin
                            state_r <= BUSY;
                            cnt_r   <= 8'd1;
                        end
                    end else if (Halt && !StallIn) begin
                        state_r <= HALTED;
                        halt_r  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (!req_s) begin
                        // Request withdrawn upstream: abandon it quietly.
                        state_r <= IDLE;
                        cnt_r   <= 8'd0;
                    end else if (MemDone) begin
                        state_r <= StallIn ? HOLD : IDLE;
                        cnt_r   <= 8'd0;
                    end else if (cnt_hit_s) begin
                        state_r <= ERROR;
                        cnt_r   <= cnt_inc_s;
                        err_r   <= 1'b1;
                        halt_r  <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_inc_s;
                    end
                end
                HOLD: begin
                    // The access has finished but EX/MEM is frozen, so it must not be reissued.
                    if (!StallIn) begin
                        state_r <= IDLE;
                    end
                end
                HALTED: begin
                    halt_r <= 1'b1;
                end
                ERROR: begin
                    err_r  <= 1'b1;
                    halt_r <= 1'b1;
                end
                default: begin
                    state_r <= ERROR;
                    err_r   <= 1'b1;
                    halt_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl (TIMEOUT=4). Load data expected
// from the memory is queued when a load is driven and popped when the
// access completes.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Address;
    logic [15:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic        MemToReg;
    logic        Halt;
    logic        StallIn;
    logic        MemDone;
    logic [15:0] MemDataOut;
    logic        MemRdEn;
    logic        MemWrEn;
    logic [15:0] MemAddr;
    logic [15:0] MemDataIn;
    logic [15:0] ReadData;
    logic        MemToReg_Out;
    logic        Stall;
    logic        Halt_Out;
    logic        Err;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .Halt(Halt), .StallIn(StallIn), .MemDone(MemDone),
        .MemDataOut(MemDataOut), .MemRdEn(MemRdEn), .MemWrEn(MemWrEn),
        .MemAddr(MemAddr), .MemDataIn(MemDataIn), .ReadData(ReadData),
        .MemToReg_Out(MemToReg_Out), .Stall(Stall), .Halt_Out(Halt_Out),
        .Err(Err)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge so that inputs can be driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Address = 16'h0000; WriteData = 16'h0000; MemRead = 1'b0; MemWrite = 1'b0;
        MemToReg = 1'b0; Halt = 1'b0; StallIn = 1'b0; MemDone = 1'b0; MemDataOut = 16'h0000;
    endtask

    task automatic do_reset();
        next_cycle();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({MemRdEn, MemWrEn, Stall, Halt_Out, Err} !== 5'b00000) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {MemRdEn, MemWrEn, Stall, Halt_Out, Err}); end
        checks++; if (ReadData !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h want 0000", ReadData); end
    endtask

    task automatic test_load_multicycle();
        next_cycle();
        Address = 16'h0010; MemRead = 1'b1; MemDone = 1'b0;
        exp_q.push_back(16'hBEEF);
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin MemDone = 1'b1; MemDataOut = 16'hBEEF; end
            @(negedge clk);
            checks++; if (MemRdEn !== 1'b1) begin errors++; $display("FAIL load_rden c%0d: got %b want 1", c, MemRdEn); end
            checks++; if (Stall !== (c < 3)) begin errors++; $display("FAIL load_stall c%0d: got %b want %b", c, Stall, (c < 3)); end
            checks++; if (MemAddr !== 16'h0010) begin errors++; $display("FAIL load_addr c%0d: got %h want 0010", c, MemAddr); end
            if (c == 3) begin
                exp_v = exp_q.pop_front();
                checks++; if (ReadData !== exp_v) begin errors++; $display("FAIL load_rdata: got %h want %h", ReadData, exp_v); end
            end
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        checks++; if ({MemRdEn, Stall} !== 2'b00) begin errors++; $display("FAIL load_after: got rden/stall %b want 00", {MemRdEn, Stall}); end
        checks++; if (ReadData !== 16'hBEEF) begin errors++; $display("FAIL load_held: got %h want beef", ReadData); end
    endtask

    task automatic test_zero_wait_store();
        next_cycle();
        Address = 16'h0020; WriteData = 16'h1234; MemWrite = 1'b1; MemDone = 1'b1; MemToReg = 1'b1;
        @(negedge clk);
        checks++; if ({MemWrEn, MemRdEn, Stall} !== 3'b100) begin errors++; $display("FAIL store_strobe: got wr/rd/stall %b want 100", {MemWrEn, MemRdEn, Stall}); end
        checks++; if (MemDataIn !== 16'h1234) begin errors++; $display("FAIL store_data: got %h want 1234", MemDataIn); end
        checks++; if (MemToReg_Out !== 1'b1) begin errors++; $display("FAIL store_m2r: got %b want 1", MemToReg_Out); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if ({MemWrEn, Stall} !== 2'b00) begin errors++; $display("FAIL store_after: got wr/stall %b want 00", {MemWrEn, Stall}); end
        checks++; if (ReadData !== 16'hBEEF) begin errors++; $display("FAIL store_rdata: got %h want beef", ReadData); end
    endtask

    task automatic test_stall_hold();
        next_cycle();
        Address = 16'h0040; MemRead = 1'b1; MemDone = 1'b1; MemDataOut = 16'hCAFE; StallIn = 1'b1;
        exp_q.push_back(16'hCAFE);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        checks++; if ({MemRdEn, Stall} !== 2'b10) begin errors++; $display("FAIL hold_issue: got rden/stall %b want 10", {MemRdEn, Stall}); end
        checks++; if (ReadData !== exp_v) begin errors++; $display("FAIL hold_rdata0: got %h want %h", ReadData, exp_v); end
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            MemDone = (c == 2); MemDataOut = 16'hDEAD;
            @(negedge clk);
            checks++; if ({MemRdEn, Stall} !== 2'b01) begin errors++; $display("FAIL hold_c%0d: got rden/stall %b want 01", c, {MemRdEn, Stall}); end
            checks++; if (ReadData !== 16'hCAFE) begin errors++; $display("FAIL hold_rdata c%0d: got %h want cafe", c, ReadData); end
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if ({MemRdEn, Stall} !== 2'b00) begin errors++; $display("FAIL hold_release: got rden/stall %b want 00", {MemRdEn, Stall}); end
        next_cycle();
        Address = 16'h0042; MemRead = 1'b1; MemDone = 1'b1; MemDataOut = 16'h5A5A;
        exp_q.push_back(16'h5A5A);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        checks++; if ({MemRdEn, Stall} !== 2'b10) begin errors++; $display("FAIL back_to_back_strobe: got rden/stall %b want 10", {MemRdEn, Stall}); end
        checks++; if (ReadData !== exp_v) begin errors++; $display("FAIL back_to_back_rdata: got %h want %h", ReadData, exp_v); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_error();
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            Address = (k == 0) ? 16'h0011 : 16'h0030; MemRead = 1'b1; MemWrite = (k == 1);
            @(negedge clk);
            checks++; if ({MemRdEn, MemWrEn, Stall, Err} !== 4'b0000) begin errors++; $display("FAIL err_issue k%0d: got rd/wr/stall/err %b want 0000", k, {MemRdEn, MemWrEn, Stall, Err}); end
            next_cycle();
            @(negedge clk);
            checks++; if ({Err, Halt_Out, MemRdEn, MemWrEn} !== 4'b1100) begin errors++; $display("FAIL err_set k%0d: got err/halt/rd/wr %b want 1100", k, {Err, Halt_Out, MemRdEn, MemWrEn}); end
            next_cycle();
            clear_inputs();
            next_cycle();
            @(negedge clk);
            checks++; if ({Err, Halt_Out} !== 2'b11) begin errors++; $display("FAIL err_sticky k%0d: got %b want 11", k, {Err, Halt_Out}); end
            do_reset();
            @(negedge clk);
            checks++; if ({Err, Halt_Out} !== 2'b00) begin errors++; $display("FAIL err_clear k%0d: got %b want 00", k, {Err, Halt_Out}); end
        end
    endtask

    task automatic test_timeout();
        next_cycle();
        Address = 16'h0050; MemRead = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++; if ({MemRdEn, Stall, Err, Halt_Out} !== ((c <= 4) ? 4'b1100 : 4'b0011)) begin
                errors++; $display("FAIL timeout c%0d: got rd/stall/err/halt %b want %b", c, {MemRdEn, Stall, Err, Halt_Out}, ((c <= 4) ? 4'b1100 : 4'b0011));
            end
            next_cycle();
        end
        do_reset();
    endtask

    task automatic test_halt();
        next_cycle();
        Halt = 1'b1;
        @(negedge clk);
        checks++; if (Halt_Out !== 1'b0) begin errors++; $display("FAIL halt_early: got %b want 0", Halt_Out); end
        next_cycle();
        Halt = 1'b0;
        @(negedge clk);
        checks++; if ({Halt_Out, Err} !== 2'b10) begin errors++; $display("FAIL halt_set: got halt/err %b want 10", {Halt_Out, Err}); end
        do_reset();
        next_cycle();
        Address = 16'h0060; WriteData = 16'h7777; MemWrite = 1'b1; Halt = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            MemDone = (c == 3);
            @(negedge clk);
            checks++; if ({MemWrEn, Halt_Out} !== 2'b10) begin errors++; $display("FAIL halt_store c%0d: got wr/halt %b want 10", c, {MemWrEn, Halt_Out}); end
            next_cycle();
        end
        MemWrite = 1'b0; MemDone = 1'b0;
        @(negedge clk);
        checks++; if ({MemWrEn, Halt_Out} !== 2'b00) begin errors++; $display("FAIL halt_after_store: got wr/halt %b want 00", {MemWrEn, Halt_Out}); end
        next_cycle();
        @(negedge clk);
        checks++; if (Halt_Out !== 1'b1) begin errors++; $display("FAIL halt_final: got %b want 1", Halt_Out); end
        do_reset();
    endtask

    task automatic test_reset_busy();
        next_cycle();
        Address = 16'h0070; MemRead = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++; if ({MemRdEn, Stall} !== 2'b11) begin errors++; $display("FAIL rstbusy_busy: got rd/stall %b want 11", {MemRdEn, Stall}); end
        next_cycle();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({MemRdEn, MemWrEn, Stall, Halt_Out, Err} !== 5'b00000) begin errors++; $display("FAIL rstbusy_out: got %b want 00000", {MemRdEn, MemWrEn, Stall, Halt_Out, Err}); end
        checks++; if (ReadData !== 16'h0000) begin errors++; $display("FAIL rstbusy_rdata: got %h want 0000", ReadData); end
        next_cycle();
        Address = 16'h0072; MemRead = 1'b1; MemDone = 1'b1; MemDataOut = 16'h0F0F;
        exp_q.push_back(16'h0F0F);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        checks++; if ({MemRdEn, Stall} !== 2'b10) begin errors++; $display("FAIL rstbusy_reissue: got rd/stall %b want 10", {MemRdEn, Stall}); end
        checks++; if (ReadData !== exp_v) begin errors++; $display("FAIL rstbusy_load: got %h want %h", ReadData, exp_v); end
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_multicycle();
        test_zero_wait_store();
        test_stall_hold();
        test_error();
        test_timeout();
        test_halt();
        test_reset_busy();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
